counter_down_timer: RTL and testbench
=====================================

# counter_down_timer

Loadable 8-bit down-counter with terminal-count signalling and optional auto-reload. It is the decrementing counterpart of the existing free-running up-counter. It turns a programmed value into a delay or periodic tick: load N, count down on enable, and flag a terminal count when the counter passes from 1 to 0. It sits beside the up-counter in the counter library and generates timeouts and strobes.

## Interface
Parameters:
- WIDTH, 8, counter and load-value width

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rb  input  1  reset, asynchronous and active-low. Asserting it clears all state immediately, independent of clk.
- load  input  1  synchronous load strobe, sampled on clk. Takes priority over every other input.
- load_val  input  WIDTH  value to count down from. Captured when load=1.
- en  input  1  count enable. The counter decrements only when en=1 and the block is busy.
- auto_reload  input  1  sampled at the terminal decrement. 1 = reload the captured value and keep running; 0 = stop at zero.
- count  output  WIDTH  current counter value, registered.
- busy  output  1  registered. 1 while in state RUN.
- tc  output  1  registered terminal-count pulse, one clock wide.
- zero  output  1  combinational, equals (count == 0).

## Operation
- Internal state:
  - count register
  - reload register rl (WIDTH bits)
  - 1-bit state: IDLE or RUN
  - tc register
- Reset (rb=0), applied asynchronously:
  - count=0, rl=0, state=IDLE, tc=0
  - Outputs are therefore busy=0, tc=0, zero=1.
- Priority per clock edge: load, then terminal decrement, then plain decrement, then hold.
- load=1:
  - count←load_val and rl←load_val.
  - tc←0, including when a terminal decrement would otherwise occur this cycle.
  - If load_val≠0, state←RUN. If load_val=0, state←IDLE and tc is never raised.
  - A load during RUN restarts the count from the new value.
- RUN, en=1, count>1: count←count−1, tc←0.
- RUN, en=1, count==1 (terminal decrement): tc←1.
  - auto_reload=1: count←rl and state stays RUN.
  - auto_reload=0: count←0 and state←IDLE.
- RUN, en=0: count holds and tc←0. The en input only gates decrements; it never resets anything.
- IDLE, load=0: count holds and tc←0. The en input has no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement is never applied at count=0, so there is no underflow wrap.

## Timing
- Load latency: count shows load_val in the cycle after the edge that samples load=1, and busy=1 in that same cycle.
- One-shot mode: after loading N≥1 with en held at 1, count steps N, N−1, …, 1 over N cycles. On the next edge count=0, tc=1 and busy=0 appear together.
- Auto-reload mode: with en held at 1, tc pulses every N cycles. The first pulse comes N edges after the load edge. In the tc cycle count shows N again, not 0.
- N=1 with auto_reload=1: tc stays high every cycle while en=1. This is legal and is the intended divide-by-1 behaviour.
- tc is exactly one cycle wide except in the N=1 auto-reload case.
- Deasserting en stalls the count. tc timing extends by exactly the number of stalled cycles.
- Asserting rb mid-count forces count=0, busy=0 and tc=0 without waiting for clk. After rb releases, the block stays IDLE until the next load.

## Test plan
- Reset: hold rb=0 with load=1 and en=1 toggling → count=0, busy=0, tc=0, zero=1. Release rb → outputs unchanged until a load.
- One-shot: load 3, en=1, auto_reload=0 → count 3, 2, 1, 0 on consecutive cycles. tc=1 and busy=0 in the cycle count=0. count then stays at 0.
- Auto-reload: load 4, en=1, auto_reload=1 for 13 cycles → tc high at cycles 4, 8 and 12 after the load edge. count=4 in each tc cycle and busy stays 1.
- Stall: load 5, en pattern 1,0,0,1,1,1,1 → tc one cycle after the 5th enabled edge. count holds its value through the en=0 cycles.
- Load collision: load 2, let count reach 1, then assert load with load_val=0xFF on the terminal edge → count=0xFF, tc=0, busy=1. Separately, load 0 → busy=0, tc never asserted.
- Async reset mid-run: load 200 and run 50 cycles, then pulse rb low between clock edges → count=0 and busy=0 immediately. After release, no decrement until a load.

Source files
------------

// File: rtl/counter_down_timer.sv
// ---------------------------------------------------------------------------
// counter_down_timer
//
// Loadable down-counter with terminal-count signalling and optional
// auto-reload. Load a value N and it counts down on enable. It flags a
// one-cycle terminal count when the count passes from 1 to 0. When
// auto-reload is set, it restarts from N instead of stopping.
//
// Ports:
//   clk          rising-edge clock
//   rb           asynchronous active-low reset
//   load         synchronous load strobe, highest priority
//   load_val     value to count down from, captured on load
//   en           count enable, only gates decrements while running
//   auto_reload  sampled on the terminal decrement: 1 reloads, 0 stops
//   count        current counter value (registered)
//   busy         high while the timer is running (registered)
//   tc           one-clock terminal-count pulse (registered)
//   zero         combinational flag, count == 0
// ---------------------------------------------------------------------------
module counter_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] rl;

    // Sequential core. Each edge resolves in priority order: load first,
    // then the terminal decrement (count == 1), then a plain decrement,
    // then hold. tc is cleared on every path except the terminal decrement,
    // so it forms a single-cycle pulse. A load clears tc even when it
    // lands on a terminal edge. While running, the count never reaches 0
    // through a plain decrement, so the counter cannot underflow.
    always_ff @(posedge clk or negedge rb) begin
        if (!rb) begin
            count <= '0;
            rl    <= '0;
            state <= IDLE;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_val;
            rl    <= load_val;
            tc    <= 1'b0;
            state <= (load_val != '0) ? RUN : IDLE;
        end else if (state == RUN && en && count == ONE) begin
            tc <= 1'b1;
            if (auto_reload) begin
                count <= rl;
            end else begin
                count <= '0;
                state <= IDLE;
            end
        end else if (state == RUN && en) begin
            count <= count - ONE;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
        end
    end

    // busy comes straight from the state flop, so it is still a registered
    // output. zero is deliberately combinational off the count register.
    assign busy = (state == RUN);
    assign zero = (count == '0);

endmodule

// File: tb/tb_counter_down_timer.sv
// ---------------------------------------------------------------------------
// tb_counter_down_timer
//
// Self-checking bench for counter_down_timer. Directed scenarios are
// followed by a randomized run. Every cycle is compared against a
// behavioural model that keeps the timer as plain integers: a current
// value, a remembered reload value, a running flag and a pulse flag.
// ---------------------------------------------------------------------------
module tb_counter_down_timer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rb;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             zero;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int mCount = 0;
    int mRl    = 0;
    bit mRun   = 0;
    bit mTc    = 0;

    counter_down_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rb          (rb),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch report and count a failure.
    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput(input string tag);
        checkValue({tag, ".count"}, 32'(count), 32'(mCount));
        checkValue({tag, ".busy"},  32'(busy),  32'(mRun));
        checkValue({tag, ".tc"},    32'(tc),    32'(mTc));
        checkValue({tag, ".zero"},  32'(zero),  32'(mCount == 0));
    endtask

    // Reference behaviour for one rising edge, from the timer's rules.
    task automatic modelEdge(input bit ld, input int val, input bit e, input bit ar);
        if (!rb) begin
            mCount = 0; mRl = 0; mRun = 0; mTc = 0;
        end else if (ld) begin
            mCount = val;
            mRl    = val;
            mRun   = (val != 0);
            mTc    = 0;
        end else if (mRun && e) begin
            if (mCount == 1) begin
                mTc = 1;
                if (ar) begin
                    mCount = mRl;
                end else begin
                    mCount = 0;
                    mRun   = 0;
                end
            end else begin
                mCount = mCount - 1;
                mTc    = 0;
            end
        end else begin
            mTc = 0;
        end
    endtask

    // Drive inputs, take one edge, then check 1 time unit after the edge.
    task automatic applyStimulus(input bit ld, input int val, input bit e, input bit ar, input string tag);
        load        = ld;
        load_val    = WIDTH'(val);
        en          = e;
        auto_reload = ar;
        @(posedge clk);
        modelEdge(ld, val, e, ar);
        #1;
        checkOutput(tag);
    endtask

    // Pulse reset low between edges and check that it acts without a clock.
    task automatic pulseReset(input string tag);
        #2;
        rb = 1'b0;
        #1;
        mCount = 0; mRl = 0; mRun = 0; mTc = 0;
        checkOutput(tag);
        #1;
        rb = 1'b1;
    endtask

    initial begin
        rb = 1'b1; load = 0; load_val = '0; en = 0; auto_reload = 0;
        #1;
        rb = 1'b0;

        // reset held: load/en toggling must not disturb anything
        for (int i = 0; i < 4; i++) applyStimulus(i[0], 8'h33, ~i[0], 1'b1, "reset_hold");
        checkValue("reset.zero_const", 32'(zero), 32'd1);
        #2 rb = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, "reset_release");

        // one-shot load 3
        applyStimulus(1, 3, 1, 0, "oneshot_load");
        checkValue("oneshot.count3", 32'(count), 32'd3);
        applyStimulus(0, 0, 1, 0, "oneshot");
        applyStimulus(0, 0, 1, 0, "oneshot");
        applyStimulus(0, 0, 1, 0, "oneshot_term");
        checkValue("oneshot.tc_const", 32'(tc), 32'd1);
        checkValue("oneshot.busy_const", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, "oneshot_after");

        // auto-reload load 4, 13 cycles
        applyStimulus(1, 4, 1, 1, "auto_load");
        for (int k = 1; k <= 13; k++) begin
            applyStimulus(0, 0, 1, 1, "auto");
            if (k % 4 == 0) begin
                checkValue("auto.tc_const", 32'(tc), 32'd1);
                checkValue("auto.count4", 32'(count), 32'd4);
            end
        end

        // stall: load 5 then en 1,0,0,1,1,1,1
        applyStimulus(1, 5, 0, 0, "stall_load");
        applyStimulus(0, 0, 1, 0, "stall");
        applyStimulus(0, 0, 0, 0, "stall_hold");
        applyStimulus(0, 0, 0, 0, "stall_hold");
        applyStimulus(0, 0, 1, 0, "stall");
        applyStimulus(0, 0, 1, 0, "stall");
        applyStimulus(0, 0, 1, 0, "stall");
        applyStimulus(0, 0, 1, 0, "stall_term");
        checkValue("stall.tc_const", 32'(tc), 32'd1);

        // load collision on the terminal edge
        applyStimulus(1, 2, 1, 0, "coll_load");
        applyStimulus(0, 0, 1, 0, "coll_one");
        applyStimulus(1, 8'hFF, 1, 0, "coll_term");
        checkValue("coll.count_ff", 32'(count), 32'hFF);
        checkValue("coll.tc_const", 32'(tc), 32'd0);
        // load 0 stays idle, no tc
        applyStimulus(1, 0, 1, 1, "load0");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, "load0_after");

        // async reset mid-run
        applyStimulus(1, 200, 1, 0, "areset_load");
        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 1, 0, "areset_run");
        pulseReset("areset_now");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, "areset_after");

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            bit ld;
            int val;
            ld  = ($urandom_range(0, 9) == 0);
            val = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
            applyStimulus(ld, val, ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 99) == 0) pulseReset("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
